fpu_minmax16: RTL and testbench

//  Streaming fp16 min/max reducer downstream of fpuComp16. Accepts a framed stream of fp16

---
 rtl/fpu_minmax16.sv | 137 +++++++++++++
 tb/tb_fpu_minmax16.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_minmax16.sv
// Streaming fp16 min/max reducer: one result beat per framed input stream.
// NaN beats are screened out before the two fpuComp16 comparators.

module fpuComp16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [1:0]  ord_o
);
  logic        bothZero;
  logic [15:0] keyA;
  logic [15:0] keyB;

  // Map fp16 to an unsigned key whose integer order matches numeric order; +0/-0 tie.
  always_comb begin
    bothZero = (a_i[14:0] == 15'h0) && (b_i[14:0] == 15'h0);
    keyA     = a_i[15] ? ~a_i : {1'b1, a_i[14:0]};
    keyB     = b_i[15] ? ~b_i : {1'b1, b_i[14:0]};
    ord_o    = 2'b00;
    if (!bothZero) begin
      if (keyA < keyB) begin
        ord_o = 2'b01;
      end else if (keyA > keyB) begin
        ord_o = 2'b10;
      end
    end
  end
endmodule

module fpu_minmax16 #(
  parameter int CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             inValid_i,
  output logic             inReady_o,
  input  logic [15:0]      inData_i,
  input  logic             inLast_i,
  output logic             outValid_o,
  input  logic             outReady_i,
  output logic [15:0]      outMin_o,
  output logic [15:0]      outMax_o,
  output logic [CNT_W-1:0] outCount_o,
  output logic             outNaN_o,
  output logic             outEmpty_o
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [15:0]      min_q, min_d;
  logic [15:0]      max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             haveVal_q, haveVal_d;
  logic             nanSeen_q, nanSeen_d;

  logic        accept;
  logic        isNaN;
  logic [15:0] cmpData;
  logic [1:0]  minOrd;
  logic [1:0]  maxOrd;

  assign isNaN   = (inData_i[14:10] == 5'h1F) && (inData_i[9:0] != 10'h0);
  assign cmpData = isNaN ? 16'h0000 : inData_i;
  assign accept  = inValid_i && inReady_o;

  fpuComp16 cmpMin (.a_i(cmpData), .b_i(min_q), .ord_o(minOrd));
  fpuComp16 cmpMax (.a_i(cmpData), .b_i(max_q), .ord_o(maxOrd));

  assign inReady_o  = (state_q != DONE);
  assign outValid_o = (state_q == DONE);
  assign outMin_o   = min_q;
  assign outMax_o   = max_q;
  assign outCount_o = count_q;
  assign outNaN_o   = nanSeen_q;
  // Qualified by DONE so the flag reads 0 out of reset, when no frame has been seen.
  assign outEmpty_o = (state_q == DONE) && !haveVal_q;

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    count_d   = count_q;
    haveVal_d = haveVal_q;
    nanSeen_d = nanSeen_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (isNaN) begin
            nanSeen_d = 1'b1;
          end else begin
            if (!haveVal_q) begin
              min_d     = inData_i;
              max_d     = inData_i;
              haveVal_d = 1'b1;
            end else begin
              if (minOrd == 2'b01) min_d = inData_i;
              if (maxOrd == 2'b10) max_d = inData_i;
            end
            if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
          end
          state_d = inLast_i ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (outReady_i) begin
          min_d     = 16'h0000;
          max_d     = 16'h0000;
          count_d   = '0;
          haveVal_d = 1'b0;
          nanSeen_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      min_q     <= 16'h0000;
      max_q     <= 16'h0000;
      count_q   <= '0;
      haveVal_q <= 1'b0;
      nanSeen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      count_q   <= count_d;
      haveVal_q <= haveVal_d;
      nanSeen_q <= nanSeen_d;
    end
  end
endmodule

// File: tb/tb_fpu_minmax16.sv
// Directed bench for fpu_minmax16; a second instance with CNT_W=2 shares the inputs
// so count saturation can be observed on the same frames.
module tb_fpu_minmax16;
  logic        clock;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [15:0] inData;
  logic        inLast;
  logic        outValid;
  logic        outReady;
  logic [15:0] outMin;
  logic [15:0] outMax;
  logic [7:0]  outCount;
  logic        outNaN;
  logic        outEmpty;

  logic        inReadyS;
  logic        outValidS;
  logic [15:0] outMinS;
  logic [15:0] outMaxS;
  logic [1:0]  outCountS;
  logic        outNaNS;
  logic        outEmptyS;

  int total = 0;
  int bad   = 0;

  fpu_minmax16 #(.CNT_W(8)) dut (
    .clock_i(clock), .reset_i(reset), .inValid_i(inValid), .inReady_o(inReady),
    .inData_i(inData), .inLast_i(inLast), .outValid_o(outValid), .outReady_i(outReady),
    .outMin_o(outMin), .outMax_o(outMax), .outCount_o(outCount), .outNaN_o(outNaN),
    .outEmpty_o(outEmpty)
  );

  fpu_minmax16 #(.CNT_W(2)) dutSmall (
    .clock_i(clock), .reset_i(reset), .inValid_i(inValid), .inReady_o(inReadyS),
    .inData_i(inData), .inLast_i(inLast), .outValid_o(outValidS), .outReady_i(outReady),
    .outMin_o(outMinS), .outMax_o(outMaxS), .outCount_o(outCountS), .outNaN_o(outNaNS),
    .outEmpty_o(outEmptyS)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one beat and returns #1 after the edge on which it was accepted.
  task automatic sendBeat(input logic [15:0] data, input logic last);
    int waited = 0;
    inValid = 1'b1;
    inData  = data;
    inLast  = last;
    while (!inReady && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    total++;
    if (!inReady) begin
      bad++;
      $display("[TB] FAIL accept_timeout: inReady=%0b required=1 data=%h", inReady, data);
    end
    @(posedge clock); #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  // Captures the result outputs now, then completes the result handshake.
  task automatic collectResult(output logic v, output logic [15:0] mn, output logic [15:0] mx,
                               output logic [7:0] cnt, output logic [1:0] cntS,
                               output logic nan, output logic emp, output logic vAfter);
    v    = outValid;
    mn   = outMin;
    mx   = outMax;
    cnt  = outCount;
    cntS = outCountS;
    nan  = outNaN;
    emp  = outEmpty;
    outReady = 1'b1;
    @(posedge clock); #1;
    outReady = 1'b0;
    vAfter = outValid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inValid = 1'b0; inData = 16'h0; inLast = 1'b0; outReady = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    total += 7;
    if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_outValid: got=%0b want=0", outValid); end
    if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_inReady: got=%0b want=1", inReady); end
    if (outMin !== 16'h0) begin bad++; $display("[TB] FAIL reset_outMin: got=%h want=0000", outMin); end
    if (outMax !== 16'h0) begin bad++; $display("[TB] FAIL reset_outMax: got=%h want=0000", outMax); end
    if (outCount !== 8'd0) begin bad++; $display("[TB] FAIL reset_outCount: got=%0d want=0", outCount); end
    if (outNaN !== 1'b0) begin bad++; $display("[TB] FAIL reset_outNaN: got=%0b want=0", outNaN); end
    if (outEmpty !== 1'b0) begin bad++; $display("[TB] FAIL reset_outEmpty: got=%0b want=0", outEmpty); end
  endtask

  task automatic test_frame(input string name, input logic [15:0] vals[$],
                            input logic [15:0] expMin, input logic [15:0] expMax,
                            input logic [7:0] expCnt, input logic [1:0] expCntS,
                            input logic expNaN, input logic expEmpty);
    logic v, vAfter, nan, emp;
    logic [15:0] mn, mx;
    logic [7:0] cnt;
    logic [1:0] cntS;
    foreach (vals[i]) sendBeat(vals[i], i == vals.size() - 1);
    collectResult(v, mn, mx, cnt, cntS, nan, emp, vAfter);
    total += 8;
    if (v !== 1'b1) begin bad++; $display("[TB] FAIL %s_outValid: got=%0b want=1", name, v); end
    if (mn !== expMin) begin bad++; $display("[TB] FAIL %s_outMin: got=%h want=%h", name, mn, expMin); end
    if (mx !== expMax) begin bad++; $display("[TB] FAIL %s_outMax: got=%h want=%h", name, mx, expMax); end
    if (cnt !== expCnt) begin bad++; $display("[TB] FAIL %s_outCount: got=%0d want=%0d", name, cnt, expCnt); end
    if (cntS !== expCntS) begin bad++; $display("[TB] FAIL %s_outCountSat: got=%0d want=%0d", name, cntS, expCntS); end
    if (nan !== expNaN) begin bad++; $display("[TB] FAIL %s_outNaN: got=%0b want=%0b", name, nan, expNaN); end
    if (emp !== expEmpty) begin bad++; $display("[TB] FAIL %s_outEmpty: got=%0b want=%0b", name, emp, expEmpty); end
    if (vAfter !== 1'b0) begin bad++; $display("[TB] FAIL %s_release: got=%0b want=0", name, vAfter); end
  endtask

  task automatic test_basic();
    test_frame("basic", '{16'h3C00, 16'hCB00, 16'h5770}, 16'hCB00, 16'h5770, 8'd3, 2'd3, 1'b0, 1'b0);
  endtask

  task automatic test_single_and_inf();
    test_frame("single", '{16'h4B48}, 16'h4B48, 16'h4B48, 8'd1, 2'd1, 1'b0, 1'b0);
    test_frame("inf", '{16'h7C00, 16'hFC00}, 16'hFC00, 16'h7C00, 8'd2, 2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_nan();
    test_frame("nanmix", '{16'h7E00, 16'h47D5, 16'h7C01}, 16'h47D5, 16'h47D5, 8'd1, 2'd1, 1'b1, 1'b0);
    test_frame("nanonly", '{16'h7E00}, 16'h0000, 16'h0000, 8'd0, 2'd0, 1'b1, 1'b1);
  endtask

  task automatic test_zero_and_sat();
    test_frame("signzero", '{16'h8000, 16'h0000}, 16'h8000, 16'h8000, 8'd2, 2'd2, 1'b0, 1'b0);
    test_frame("sat", '{16'h4400, 16'h3C00, 16'h0001, 16'h4500, 16'h4200},
               16'h0001, 16'h4500, 8'd5, 2'd3, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic v, vAfter, nan, emp;
    logic [15:0] mn, mx;
    logic [7:0] cnt;
    logic [1:0] cntS;
    sendBeat(16'hC000, 1'b1);
    inValid = 1'b1; inData = 16'h4000; inLast = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total += 4;
      if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL stall_outValid c=%0d: got=%0b want=1", c, outValid); end
      if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL stall_inReady c=%0d: got=%0b want=0", c, inReady); end
      if (outMin !== 16'hC000) begin bad++; $display("[TB] FAIL stall_outMin c=%0d: got=%h want=C000", c, outMin); end
      if (outCount !== 8'd1) begin bad++; $display("[TB] FAIL stall_outCount c=%0d: got=%0d want=1", c, outCount); end
      @(posedge clock); #1;
    end
    outReady = 1'b1;
    @(posedge clock); #1;
    outReady = 1'b0;
    total += 2;
    if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL stall_idle_outValid: got=%0b want=0", outValid); end
    if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL stall_idle_inReady: got=%0b want=1", inReady); end
    @(posedge clock); #1;
    inValid = 1'b0; inLast = 1'b0;
    collectResult(v, mn, mx, cnt, cntS, nan, emp, vAfter);
    total += 4;
    if (v !== 1'b1) begin bad++; $display("[TB] FAIL held_outValid: got=%0b want=1", v); end
    if (mn !== 16'h4000) begin bad++; $display("[TB] FAIL held_outMin: got=%h want=4000", mn); end
    if (mx !== 16'h4000) begin bad++; $display("[TB] FAIL held_outMax: got=%h want=4000", mx); end
    if (cnt !== 8'd1) begin bad++; $display("[TB] FAIL held_outCount: got=%0d want=1", cnt); end
  endtask

  task automatic test_reset_midframe();
    sendBeat(16'h5000, 1'b0);
    sendBeat(16'hD000, 1'b0);
    reset = 1'b1;
    #2;
    total += 4;
    if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_outValid: got=%0b want=0", outValid); end
    if (outMin !== 16'h0) begin bad++; $display("[TB] FAIL midreset_outMin: got=%h want=0000", outMin); end
    if (outMax !== 16'h0) begin bad++; $display("[TB] FAIL midreset_outMax: got=%h want=0000", outMax); end
    if (outCount !== 8'd0) begin bad++; $display("[TB] FAIL midreset_outCount: got=%0d want=0", outCount); end
    @(posedge clock); #1;
    reset = 1'b0;
    test_frame("afterreset", '{16'h3C00}, 16'h3C00, 16'h3C00, 8'd1, 2'd1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_and_inf();
    test_nan();
    test_back_to_back();
    test_zero_and_sat();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
